// File: rtl/psx_host_poller.sv
// Console-side PSX controller poller: runs a periodic 5-byte digital poll frame,
// checks the pad header and publishes an active-high 16-bit button word.
module psx_host_poller #(
   parameter int CLK_DIV       = 100,
   parameter int ATT_SETUP     = 1000,
   parameter int ACK_TIMEOUT   = 5000,
   parameter int POLL_INTERVAL = 833333
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        enable,
   input  logic        psx_data,
   input  logic        psx_ack,
   output logic        psx_att,
   output logic        psx_clk,
   output logic        psx_cmd,
   output logic [15:0] buttons,
   output logic        btn_valid,
   output logic        link_err,
   output logic        busy
);

   localparam int CNT_MAX = (ATT_SETUP > CLK_DIV) ? ATT_SETUP : CLK_DIV;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam int TO_W    = $clog2(ACK_TIMEOUT + 1);
   localparam int PER_W   = $clog2(POLL_INTERVAL + 1);

   localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(ATT_SETUP - 1);
   localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(CLK_DIV - 1);
   localparam logic [TO_W-1:0]  TO_LAST    = TO_W'(ACK_TIMEOUT - 1);
   localparam logic [PER_W-1:0] PER_LAST   = PER_W'(POLL_INTERVAL - 1);

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_SETUP    = 3'd1;
   localparam logic [2:0] S_BIT_LO   = 3'd2;
   localparam logic [2:0] S_BIT_HI   = 3'd3;
   localparam logic [2:0] S_ACK_WAIT = 3'd4;
   localparam logic [2:0] S_ACK_REL  = 3'd5;
   localparam logic [2:0] S_FINISH   = 3'd6;

   logic             data_p0, data_p1;
   logic             ack_p0, ack_p1;
   logic [PER_W-1:0] per_cnt;
   logic             per_wrap;
   logic [2:0]       state;
   logic [CNT_W-1:0] cnt;
   logic [TO_W-1:0]  to_cnt;
   logic [2:0]       bit_idx;
   logic [2:0]       byte_idx;
   logic [1:0]       rx_slot;
   logic [31:0]      rx_word;
   logic             timed_out;

   function automatic logic tx_bit(input logic [2:0] byte_i, input logic [2:0] bit_i);
      logic [7:0] b;
      case (byte_i)
         3'd0:    b = 8'h01;
         3'd1:    b = 8'h42;
         default: b = 8'h00;
      endcase
      return b[bit_i];
   endfunction

   // rx_word holds bytes 1..4; byte 0 carries nothing the console needs
   function automatic logic header_ok(input logic [31:0] w);
      return (w[7:0] == 8'h41) && (w[15:8] == 8'h5A);
   endfunction

   assign per_wrap = (per_cnt == PER_LAST);
   assign rx_slot  = 2'(byte_idx - 3'd1);

   // stage p0/p1: two-flop synchronizers for the asynchronous pad lines
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_p0 <= 1'b1;
         data_p1 <= 1'b1;
         ack_p0  <= 1'b1;
         ack_p1  <= 1'b1;
      end else begin
         data_p0 <= psx_data;
         data_p1 <= data_p0;
         ack_p0  <= psx_ack;
         ack_p1  <= ack_p0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)        per_cnt <= '0;
      else if (per_wrap) per_cnt <= '0;
      else               per_cnt <= per_cnt + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         cnt       <= '0;
         to_cnt    <= '0;
         bit_idx   <= '0;
         byte_idx  <= '0;
         rx_word   <= '0;
         timed_out <= 1'b0;
         psx_att   <= 1'b1;
         psx_clk   <= 1'b1;
         psx_cmd   <= 1'b1;
         busy      <= 1'b0;
         buttons   <= '0;
         btn_valid <= 1'b0;
         link_err  <= 1'b0;
      end else begin
         btn_valid <= 1'b0;
         case (state)
            S_IDLE: begin
               if (per_wrap && enable) begin
                  state     <= S_SETUP;
                  psx_att   <= 1'b0;
                  busy      <= 1'b1;
                  cnt       <= '0;
                  to_cnt    <= '0;
                  bit_idx   <= '0;
                  byte_idx  <= '0;
                  timed_out <= 1'b0;
               end
            end
            S_SETUP: begin
               if (cnt == SETUP_LAST) begin
                  state   <= S_BIT_LO;
                  cnt     <= '0;
                  psx_clk <= 1'b0;
                  psx_cmd <= tx_bit(byte_idx, bit_idx);
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_BIT_LO: begin
               if (cnt == DIV_LAST) begin
                  state   <= S_BIT_HI;
                  cnt     <= '0;
                  psx_clk <= 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_BIT_HI: begin
               if (cnt == DIV_LAST) begin
                  cnt <= '0;
                  if (byte_idx != 3'd0) rx_word[{rx_slot, bit_idx}] <= data_p1;
                  if (bit_idx == 3'd7) begin
                     bit_idx <= '0;
                     psx_cmd <= 1'b1;
                     if (byte_idx == 3'd4) begin
                        state   <= S_FINISH;
                        psx_att <= 1'b1;
                        busy    <= 1'b0;
                     end else begin
                        state    <= S_ACK_WAIT;
                        to_cnt   <= '0;
                        byte_idx <= byte_idx + 3'd1;
                     end
                  end else begin
                     state   <= S_BIT_LO;
                     bit_idx <= bit_idx + 3'd1;
                     psx_clk <= 1'b0;
                     psx_cmd <= tx_bit(byte_idx, bit_idx + 3'd1);
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_ACK_WAIT: begin
               if (!ack_p1) begin
                  state  <= S_ACK_REL;
                  to_cnt <= to_cnt + 1'b1;
               end else if (to_cnt == TO_LAST) begin
                  state     <= S_FINISH;
                  timed_out <= 1'b1;
                  psx_att   <= 1'b1;
                  busy      <= 1'b0;
               end else begin
                  to_cnt <= to_cnt + 1'b1;
               end
            end
            S_ACK_REL: begin
               if (ack_p1) begin
                  state   <= S_BIT_LO;
                  cnt     <= '0;
                  psx_clk <= 1'b0;
                  psx_cmd <= tx_bit(byte_idx, 3'd0);
               end else if (to_cnt == TO_LAST) begin
                  state     <= S_FINISH;
                  timed_out <= 1'b1;
                  psx_att   <= 1'b1;
                  busy      <= 1'b0;
               end else begin
                  to_cnt <= to_cnt + 1'b1;
               end
            end
            S_FINISH: begin
               state <= S_IDLE;
               if (!timed_out && header_ok(rx_word)) begin
                  buttons   <= ~rx_word[31:16];
                  btn_valid <= 1'b1;
                  link_err  <= 1'b0;
               end else begin
                  link_err <= 1'b1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_psx_host_poller.sv
// Bench for psx_host_poller: behavioural pad model plus cmd/button scoreboards.
module tb_psx_host_poller;

   localparam int CLK_DIV       = 4;
   localparam int ATT_SETUP     = 8;
   localparam int ACK_TIMEOUT   = 50;
   localparam int POLL_INTERVAL = 2000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        enable = 1'b0;
   logic        psx_data = 1'b1;
   logic        psx_ack = 1'b1;
   logic        psx_att, psx_clk, psx_cmd;
   logic [15:0] buttons;
   logic        btn_valid, link_err, busy;

   psx_host_poller #(
      .CLK_DIV(CLK_DIV), .ATT_SETUP(ATT_SETUP),
      .ACK_TIMEOUT(ACK_TIMEOUT), .POLL_INTERVAL(POLL_INTERVAL)
   ) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .psx_data(psx_data), .psx_ack(psx_ack),
      .psx_att(psx_att), .psx_clk(psx_clk), .psx_cmd(psx_cmd), .buttons(buttons),
      .btn_valid(btn_valid), .link_err(link_err), .busy(busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int tests_run = 0;
   int tests_failed = 0;

   logic [7:0]  exp_cmd_q[$];
   logic [7:0]  obs_cmd_q[$];
   logic [15:0] exp_btn_q[$];
   logic [15:0] obs_btn_q[$];

   // pad model state
   logic [7:0] dev_rsp [5];
   bit         dev_ack_en [5];
   int         ack_delay = 20;
   bit         spur_arm = 1'b0;
   int         dev_byte = 0, dev_bit = 0;
   int         ack_timer = 0, ack_low = 0, spur_cnt = 0;
   logic [7:0] cmd_sh = 8'h00;
   logic       d_prev_att = 1'b1, d_prev_clk = 1'b1;

   // monitor state
   int   att_falls, att_rise_cyc, last_rise_cyc, clk_falls, rises;
   int   lo_start, hi_start, lo_min, lo_max, hi_min, hi_max, btn_pulses, width;
   logic m_prev_att = 1'b1, m_prev_clk = 1'b1;

   initial begin
      forever begin
         @(negedge clk);
         if (ack_timer > 0) begin
            ack_timer--;
            if (ack_timer == 0) ack_low = 4;
         end
         if (psx_att || !rst_n) begin
            dev_byte = 0; dev_bit = 0; psx_data = 1'b1;
            ack_timer = 0; ack_low = 0; spur_cnt = 0;
         end else begin
            if (d_prev_clk && !psx_clk && dev_byte < 5) psx_data = dev_rsp[dev_byte][dev_bit];
            if (!d_prev_clk && psx_clk && dev_byte < 5) begin
               cmd_sh[dev_bit] = psx_cmd;
               if (spur_arm && dev_byte == 2 && dev_bit == 3) begin
                  spur_cnt = 2;
                  spur_arm = 1'b0;
               end
               if (dev_bit == 7) begin
                  obs_cmd_q.push_back(cmd_sh);
                  if (dev_byte < 4 && dev_ack_en[dev_byte]) ack_timer = ack_delay;
                  dev_byte++;
                  dev_bit = 0;
               end else begin
                  dev_bit++;
               end
            end
         end
         if (ack_low > 0 || spur_cnt > 0) begin
            psx_ack = 1'b0;
            if (ack_low > 0) ack_low--;
            if (spur_cnt > 0) spur_cnt--;
         end else begin
            psx_ack = 1'b1;
         end
         d_prev_att = psx_att;
         d_prev_clk = psx_clk;
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            m_prev_att = 1'b1;
            m_prev_clk = 1'b1;
         end else begin
            if (m_prev_att && !psx_att) begin att_falls++; rises = 0; end
            if (!m_prev_att && psx_att) att_rise_cyc = cyc;
            if (!psx_att) begin
               if (m_prev_clk && !psx_clk) begin
                  clk_falls++;
                  lo_start = cyc;
                  if (rises % 8 != 0) begin
                     width = cyc - hi_start;
                     if (width < hi_min) hi_min = width;
                     if (width > hi_max) hi_max = width;
                  end
               end
               if (!m_prev_clk && psx_clk) begin
                  rises++;
                  width = cyc - lo_start;
                  if (width < lo_min) lo_min = width;
                  if (width > lo_max) lo_max = width;
                  hi_start = cyc;
                  last_rise_cyc = cyc;
               end
            end
            if (btn_valid) begin
               btn_pulses++;
               obs_btn_q.push_back(buttons);
            end
            m_prev_att = psx_att;
            m_prev_clk = psx_clk;
         end
      end
   end

   task automatic clear_obs();
      obs_cmd_q.delete();
      obs_btn_q.delete();
      att_falls = 0; clk_falls = 0; rises = 0; btn_pulses = 0;
      att_rise_cyc = 0; last_rise_cyc = 0;
      lo_min = 1000000; lo_max = 0; hi_min = 1000000; hi_max = 0;
   endtask

   task automatic wait_att(input logic level, input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (psx_att === level) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic load_rsp(input logic [39:0] rsp);
      for (int i = 0; i < 5; i++) begin
         dev_rsp[i] = rsp[8*i +: 8];
         dev_ack_en[i] = 1'b1;
      end
   endtask

   // waits for idle, clears observations, then runs one whole frame
   task automatic run_frame(output bit ok);
      bit ok_a, ok_b, ok_c;
      wait_att(1'b1, 5000, ok_a);
      clear_obs();
      wait_att(1'b0, 5000, ok_b);
      wait_att(1'b1, 5000, ok_c);
      repeat (4) @(negedge clk);
      ok = ok_a && ok_b && ok_c;
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      tests_run++;
      if ({psx_att, psx_clk, psx_cmd, busy} !== 4'b1110) begin
         tests_failed++;
         $display("FAIL reset_lines: got att/clk/cmd/busy=%b required 1110", {psx_att, psx_clk, psx_cmd, busy});
      end
      tests_run++;
      if ({buttons, btn_valid, link_err} !== 18'h0) begin
         tests_failed++;
         $display("FAIL reset_outputs: got buttons=%h valid=%b err=%b required 0", buttons, btn_valid, link_err);
      end
      rst_n = 1'b1;
      enable = 1'b1;
   endtask

   task automatic test_good_frame();
      bit ok;
      logic [7:0] e, o;
      logic [15:0] eb, ob;
      load_rsp({8'hFF, 8'hFE, 8'h5A, 8'h41, 8'hFF});
      exp_cmd_q = '{8'h01, 8'h42, 8'h00, 8'h00, 8'h00};
      exp_btn_q.push_back(16'h0001);
      run_frame(ok);
      tests_run++;
      if (!ok) begin tests_failed++; $display("FAIL good_frame_timing: got no complete frame required one"); end
      while (exp_cmd_q.size() > 0) begin
         e = exp_cmd_q.pop_front();
         tests_run++;
         if (obs_cmd_q.size() == 0) begin
            tests_failed++; $display("FAIL good_cmd: got no byte required %h", e);
         end else begin
            o = obs_cmd_q.pop_front();
            if (o !== e) begin tests_failed++; $display("FAIL good_cmd: got %h required %h", o, e); end
         end
      end
      tests_run++;
      if (btn_pulses !== 1) begin tests_failed++; $display("FAIL good_valid_count: got %0d required 1", btn_pulses); end
      while (exp_btn_q.size() > 0) begin
         eb = exp_btn_q.pop_front();
         tests_run++;
         if (obs_btn_q.size() == 0) begin
            tests_failed++; $display("FAIL good_buttons: got no update required %h", eb);
         end else begin
            ob = obs_btn_q.pop_front();
            if (ob !== eb) begin tests_failed++; $display("FAIL good_buttons: got %h required %h", ob, eb); end
         end
      end
      tests_run++;
      if (link_err !== 1'b0) begin tests_failed++; $display("FAIL good_link_err: got %b required 0", link_err); end
      tests_run++;
      if (lo_min !== CLK_DIV || lo_max !== CLK_DIV) begin
         tests_failed++; $display("FAIL good_clk_low: got min %0d max %0d required %0d", lo_min, lo_max, CLK_DIV);
      end
      tests_run++;
      if (hi_min !== CLK_DIV || hi_max !== CLK_DIV) begin
         tests_failed++; $display("FAIL good_clk_high: got min %0d max %0d required %0d", hi_min, hi_max, CLK_DIV);
      end
      tests_run++;
      if (clk_falls !== 40) begin tests_failed++; $display("FAIL good_clk_count: got %0d required 40", clk_falls); end
   endtask

   task automatic test_ack_timeout();
      bit ok;
      logic [7:0] e, o;
      load_rsp({8'hFF, 8'hFE, 8'h5A, 8'h41, 8'hFF});
      dev_ack_en[1] = 1'b0;
      exp_cmd_q = '{8'h01, 8'h42};
      run_frame(ok);
      tests_run++;
      if (!ok) begin tests_failed++; $display("FAIL timeout_frame: got no complete frame required one"); end
      tests_run++;
      if (att_rise_cyc - last_rise_cyc !== CLK_DIV + ACK_TIMEOUT) begin
         tests_failed++;
         $display("FAIL timeout_abort_time: got %0d required %0d", att_rise_cyc - last_rise_cyc, CLK_DIV + ACK_TIMEOUT);
      end
      while (exp_cmd_q.size() > 0) begin
         e = exp_cmd_q.pop_front();
         tests_run++;
         if (obs_cmd_q.size() == 0) begin
            tests_failed++; $display("FAIL timeout_cmd: got no byte required %h", e);
         end else begin
            o = obs_cmd_q.pop_front();
            if (o !== e) begin tests_failed++; $display("FAIL timeout_cmd: got %h required %h", o, e); end
         end
      end
      tests_run++;
      if (obs_cmd_q.size() !== 0) begin tests_failed++; $display("FAIL timeout_extra_bytes: got %0d required 0", obs_cmd_q.size()); end
      tests_run++;
      if (link_err !== 1'b1) begin tests_failed++; $display("FAIL timeout_link_err: got %b required 1", link_err); end
      tests_run++;
      if (buttons !== 16'h0001) begin tests_failed++; $display("FAIL timeout_buttons: got %h required 0001", buttons); end
      tests_run++;
      if (btn_pulses !== 0) begin tests_failed++; $display("FAIL timeout_valid: got %0d required 0", btn_pulses); end
      tests_run++;
      if (busy !== 1'b0) begin tests_failed++; $display("FAIL timeout_busy: got %b required 0", busy); end
   endtask

   task automatic test_all_pressed_spurious();
      bit ok;
      logic [15:0] eb, ob;
      load_rsp({8'h00, 8'h00, 8'h5A, 8'h41, 8'hFF});
      spur_arm = 1'b1;
      exp_btn_q.push_back(16'hFFFF);
      run_frame(ok);
      tests_run++;
      if (!ok) begin tests_failed++; $display("FAIL pressed_frame: got no complete frame required one"); end
      tests_run++;
      if (btn_pulses !== 1) begin tests_failed++; $display("FAIL pressed_valid_count: got %0d required 1", btn_pulses); end
      while (exp_btn_q.size() > 0) begin
         eb = exp_btn_q.pop_front();
         tests_run++;
         if (obs_btn_q.size() == 0) begin
            tests_failed++; $display("FAIL pressed_buttons: got no update required %h", eb);
         end else begin
            ob = obs_btn_q.pop_front();
            if (ob !== eb) begin tests_failed++; $display("FAIL pressed_buttons: got %h required %h", ob, eb); end
         end
      end
      tests_run++;
      if (link_err !== 1'b0) begin tests_failed++; $display("FAIL pressed_link_err_cleared: got %b required 0", link_err); end
      tests_run++;
      if (lo_min !== CLK_DIV || lo_max !== CLK_DIV || hi_min !== CLK_DIV || hi_max !== CLK_DIV) begin
         tests_failed++;
         $display("FAIL spurious_ack_timing: got lo %0d..%0d hi %0d..%0d required %0d", lo_min, lo_max, hi_min, hi_max, CLK_DIV);
      end
      tests_run++;
      if (clk_falls !== 40) begin tests_failed++; $display("FAIL spurious_clk_count: got %0d required 40", clk_falls); end
   endtask

   task automatic test_analog_id();
      bit ok;
      logic [7:0] e, o;
      load_rsp({8'h00, 8'h00, 8'h5A, 8'h73, 8'hFF});
      exp_cmd_q = '{8'h01, 8'h42, 8'h00, 8'h00, 8'h00};
      run_frame(ok);
      tests_run++;
      if (!ok) begin tests_failed++; $display("FAIL analog_frame: got no complete frame required one"); end
      while (exp_cmd_q.size() > 0) begin
         e = exp_cmd_q.pop_front();
         tests_run++;
         if (obs_cmd_q.size() == 0) begin
            tests_failed++; $display("FAIL analog_cmd: got no byte required %h", e);
         end else begin
            o = obs_cmd_q.pop_front();
            if (o !== e) begin tests_failed++; $display("FAIL analog_cmd: got %h required %h", o, e); end
         end
      end
      tests_run++;
      if (clk_falls !== 40) begin tests_failed++; $display("FAIL analog_clk_count: got %0d required 40", clk_falls); end
      tests_run++;
      if (link_err !== 1'b1) begin tests_failed++; $display("FAIL analog_link_err: got %b required 1", link_err); end
      tests_run++;
      if (btn_pulses !== 0) begin tests_failed++; $display("FAIL analog_valid: got %0d required 0", btn_pulses); end
      tests_run++;
      if (buttons !== 16'hFFFF) begin tests_failed++; $display("FAIL analog_buttons_held: got %h required FFFF", buttons); end
   endtask

   task automatic test_enable();
      bit ok, ok_b;
      logic [15:0] eb, ob;
      enable = 1'b0;
      wait_att(1'b1, 5000, ok);
      clear_obs();
      repeat (3 * POLL_INTERVAL) @(negedge clk);
      tests_run++;
      if (att_falls !== 0) begin tests_failed++; $display("FAIL disabled_no_att: got %0d frames required 0", att_falls); end
      load_rsp({8'h12, 8'h34, 8'h5A, 8'h41, 8'hFF});
      exp_btn_q.push_back(16'hEDCB);
      enable = 1'b1;
      wait_att(1'b0, 2 * POLL_INTERVAL + 100, ok);
      ok_b = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         if (dev_byte == 3) begin ok_b = 1'b1; break; end
      end
      enable = 1'b0;
      tests_run++;
      if (!(ok && ok_b)) begin tests_failed++; $display("FAIL enable_drop_reach_byte3: got %b required 1", ok && ok_b); end
      wait_att(1'b1, 2000, ok);
      repeat (4) @(negedge clk);
      tests_run++;
      if (!ok) begin tests_failed++; $display("FAIL enable_drop_finish: got no frame end required one"); end
      tests_run++;
      if (btn_pulses !== 1) begin tests_failed++; $display("FAIL enable_drop_valid: got %0d required 1", btn_pulses); end
      while (exp_btn_q.size() > 0) begin
         eb = exp_btn_q.pop_front();
         tests_run++;
         if (obs_btn_q.size() == 0) begin
            tests_failed++; $display("FAIL enable_drop_buttons: got no update required %h", eb);
         end else begin
            ob = obs_btn_q.pop_front();
            if (ob !== eb) begin tests_failed++; $display("FAIL enable_drop_buttons: got %h required %h", ob, eb); end
         end
      end
      tests_run++;
      if (link_err !== 1'b0) begin tests_failed++; $display("FAIL enable_drop_link_err: got %b required 0", link_err); end
      repeat (3 * POLL_INTERVAL) @(negedge clk);
      tests_run++;
      if (att_falls !== 1) begin tests_failed++; $display("FAIL enable_drop_no_more: got %0d frames required 1", att_falls); end
   endtask

   task automatic test_reset_midframe();
      bit ok, ok_b;
      load_rsp({8'hFF, 8'hFE, 8'h5A, 8'h41, 8'hFF});
      enable = 1'b1;
      wait_att(1'b0, 2 * POLL_INTERVAL + 100, ok);
      ok_b = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         if (dev_byte == 2 && psx_clk == 1'b0) begin ok_b = 1'b1; break; end
      end
      tests_run++;
      if (!(ok && ok_b)) begin tests_failed++; $display("FAIL midreset_reach_byte2: got %b required 1", ok && ok_b); end
      rst_n = 1'b0;
      #1;
      tests_run++;
      if ({psx_att, psx_clk, psx_cmd, busy} !== 4'b1110) begin
         tests_failed++;
         $display("FAIL midreset_lines: got att/clk/cmd/busy=%b required 1110", {psx_att, psx_clk, psx_cmd, busy});
      end
      tests_run++;
      if ({buttons, btn_valid, link_err} !== 18'h0) begin
         tests_failed++;
         $display("FAIL midreset_outputs: got buttons=%h valid=%b err=%b required 0", buttons, btn_valid, link_err);
      end
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (20) @(negedge clk);
      tests_run++;
      if (psx_att !== 1'b1 || busy !== 1'b0) begin
         tests_failed++; $display("FAIL midreset_idle_after: got att=%b busy=%b required 1 0", psx_att, busy);
      end
   endtask

   initial begin
      clear_obs();
      load_rsp({8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF});
      test_reset();
      test_good_frame();
      test_ack_timeout();
      test_all_pressed_spurious();
      test_analog_id();
      test_enable();
      test_reset_midframe();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
